// File: rtl/amba_axi4lite_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
//   axi4lite_resp_t : AXI response encodings
//   merge()         : byte-strobe merge of new data into an old word (up to 64 bits)
package amba_axi4lite_regbank_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4lite_resp_t;

  localparam int MAX_DW   = 64;
  localparam int MAX_STRB = MAX_DW / 8;

  // Lanes with strb[b]=1 take the new byte, the rest keep the old byte.
  // Callers narrower than 64 bits zero-extend in and truncate out.
  function automatic logic [MAX_DW-1:0] merge(
    input logic [MAX_DW-1:0]   old_v,
    input logic [MAX_DW-1:0]   new_v,
    input logic [MAX_STRB-1:0] strb
  );
    logic [MAX_DW-1:0] r;
    r = old_v;
    for (int b = 0; b < MAX_STRB; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/amba_axi4lite_regbank_decode.sv
// Address decode for the register bank (purely combinational).
//   addr_i     : byte address from AW or AR
//   in_range_o : address falls inside the bank
//   idx_o      : register index; sub-word byte offset bits are dropped so
//                unaligned addresses hit the containing register
module amba_axi4lite_regbank_decode #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic [ADDRESS_WIDTH-1:0]    addr_i,
  output logic                        in_range_o,
  output logic [$clog2(NUM_REGS)-1:0] idx_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB        = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(NUM_REGS);

  logic [ADDRESS_WIDTH-1:0] off;

  // Subtraction wraps at ADDRESS_WIDTH, so addresses below BASE_ADDR
  // become huge offsets and fall out of range.
  assign off        = addr_i - BASE_ADDR;
  assign in_range_o = off < ADDRESS_WIDTH'(NUM_REGS * STRB_WIDTH);
  assign idx_o      = off[LSB +: IDX_W];

endmodule

// File: rtl/amba_axi4lite_regbank_subordinate.sv
// AXI4-Lite subordinate exposing NUM_REGS registers of DATA_WIDTH bits.
//   ACLK/ARESETn      : clock, synchronous active-low reset
//   AW*/W*/B*         : write channels; AW and W are buffered independently
//                       and committed together once a B slot is free
//   AR*/R*            : read channels; one outstanding read
//   regs_o            : flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// All outputs come from flops, so no VALID->READY combinational path exists.
module amba_axi4lite_regbank_subordinate
  import amba_axi4lite_regbank_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter logic [DATA_WIDTH-1:0]    RESET_VALUE   = '0,
  localparam int                      STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // ---------------- state ----------------
  logic                                 run_q;
  logic                                 aw_full_q, aw_full_d;
  logic [ADDRESS_WIDTH-1:0]             aw_addr_q, aw_addr_d;
  logic                                 w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0]                w_data_q,  w_data_d;
  logic [STRB_WIDTH-1:0]                w_strb_q,  w_strb_d;
  logic                                 bvalid_q,  bvalid_d;
  axi4lite_resp_t                       bresp_q,   bresp_d;
  logic                                 rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0]                rdata_q,   rdata_d;
  axi4lite_resp_t                       rresp_q,   rresp_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q,    regs_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Protection bits carry no meaning for this bank.
  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  // ---------------- decode ----------------
  amba_axi4lite_regbank_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR)
  ) u_wr_dec (
    .addr_i     (aw_addr_q),
    .in_range_o (wr_in_range),
    .idx_o      (wr_idx)
  );

  // Read decode runs on the live ARADDR: data is sampled on the AR handshake.
  amba_axi4lite_regbank_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR)
  ) u_rd_dec (
    .addr_i     (ARADDR),
    .in_range_o (rd_in_range),
    .idx_o      (rd_idx)
  );

  // ---------------- handshakes ----------------
  assign AWREADY = run_q & ~aw_full_q;
  assign WREADY  = run_q & ~w_full_q;
  assign ARREADY = run_q & ~rvalid_q;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID  & WREADY;
  assign ar_hs  = ARVALID & ARREADY;
  // Commit needs both halves and a B slot that is empty or draining this edge.
  assign commit = aw_full_q & w_full_q & (~bvalid_q | BREADY);

  // ---------------- write path ----------------
  // A handshake can only occur into an empty buffer, so set and clear never
  // collide on the same buffer in one cycle.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range ? OKAY : SLVERR;
    end else if (BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // Per-register next state: only the addressed register merges the strobed bytes.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic              wr_en;
    logic [MAX_DW-1:0] merged;
    assign wr_en       = commit & wr_in_range & (wr_idx == IDX_W'(i));
    assign merged      = merge(MAX_DW'(regs_q[i]), MAX_DW'(w_data_q), MAX_STRB'(w_strb_q));
    assign regs_d[i]   = wr_en ? merged[DATA_WIDTH-1:0] : regs_q[i];
  end

  // ---------------- read path ----------------
  // regs_q is the pre-commit value, so a same-edge read of a register being
  // written returns the old contents.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? regs_q[rd_idx] : '0;
      rresp_d  = rd_in_range ? OKAY : SLVERR;
    end else if (RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      run_q     <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      regs_q    <= {NUM_REGS{RESET_VALUE}};
    end else begin
      run_q     <= 1'b1;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;
  assign regs_o = regs_q;

endmodule

// File: tb/tb_amba_axi4lite_regbank_subordinate.sv
// Directed bench for the AXI4-Lite register bank: reset, write/read,
// strobes and channel ordering, out-of-range, backpressure, read/write
// collision and reset while a response is pending.
module tb_amba_axi4lite_regbank_subordinate;

  localparam int AW = 32, DW = 32, NR = 16, SW = DW / 8;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [AW-1:0]     AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID, AWREADY;
  logic [DW-1:0]     WDATA;
  logic [SW-1:0]     WSTRB;
  logic              WVALID, WREADY;
  logic [1:0]        BRESP;
  logic              BVALID, BREADY;
  logic [AW-1:0]     ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID, ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID, RREADY;
  logic [NR*DW-1:0]  regs_o;

  logic [NR*DW-1:0]  exp_regs;
  int                n_chk  = 0;
  int                n_pass = 0;

  always #5 ACLK = ~ACLK;

  amba_axi4lite_regbank_subordinate dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_aw(input logic [AW-1:0] a);
    AWADDR = a; AWVALID = 1'b1;
  endtask

  task automatic drive_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    WDATA = d; WSTRB = s; WVALID = 1'b1;
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWPROT = 3'b000; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b000; ARVALID = 1'b0; RREADY = 1'b0;
    exp_regs = '0;

    // ---- 1. reset ----
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
    end
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready",  WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bresp",   BRESP, 0);
    chk("rst_rresp",   RRESP, 0);
    chk("rst_rdata",   RDATA, 0);
    chk("rst_regs",    regs_o, exp_regs);
    ARESETn = 1'b1;
    #1;
    chk("rel_awready_pre", AWREADY, 0);
    tick();
    chk("rel_awready", AWREADY, 1);
    chk("rel_wready",  WREADY, 1);
    chk("rel_arready", ARREADY, 1);

    // ---- 2. write then read ----
    drive_aw(32'h08); drive_w(32'hDEADBEEF, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    chk("wr_bvalid_early", BVALID, 0);
    chk("wr_awready_full", AWREADY, 0);
    tick();
    exp_regs[2*DW +: DW] = 32'hDEADBEEF;
    chk("wr_bvalid", BVALID, 1);
    chk("wr_bresp",  BRESP, 2'b00);
    chk("wr_regs",   regs_o, exp_regs);
    BREADY = 1; tick(); BREADY = 0;
    chk("wr_bvalid_clr", BVALID, 0);
    ARADDR = 32'h08; ARVALID = 1;
    tick();
    ARVALID = 0;
    chk("rd_rvalid",  RVALID, 1);
    chk("rd_rdata",   RDATA, 32'hDEADBEEF);
    chk("rd_rresp",   RRESP, 2'b00);
    chk("rd_arready", ARREADY, 0);
    RREADY = 1; tick(); RREADY = 0;
    chk("rd_rvalid_clr", RVALID, 0);

    // ---- 3. strobes, W three cycles ahead of AW ----
    drive_w(32'h11223344, 4'b0101);
    tick();
    WVALID = 0;
    chk("st_wready_full", WREADY, 0);
    tick(); tick();
    chk("st_bvalid_wait", BVALID, 0);
    drive_aw(32'h0C);
    tick();
    AWVALID = 0;
    chk("st_bvalid_early", BVALID, 0);
    tick();
    exp_regs[3*DW +: DW] = 32'h00220044;
    chk("st_bvalid", BVALID, 1);
    chk("st_bresp",  BRESP, 2'b00);
    chk("st_regs",   regs_o, exp_regs);
    BREADY = 1; tick(); BREADY = 0;

    // ---- 4. out of range ----
    drive_aw(32'h40); drive_w(32'hFFFFFFFF, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    chk("oor_bvalid", BVALID, 1);
    chk("oor_bresp",  BRESP, 2'b10);
    chk("oor_regs",   regs_o, exp_regs);
    BREADY = 1; tick(); BREADY = 0;
    ARADDR = 32'h44; ARVALID = 1;
    tick();
    ARVALID = 0;
    chk("oor_rvalid", RVALID, 1);
    chk("oor_rresp",  RRESP, 2'b10);
    chk("oor_rdata",  RDATA, 0);
    RREADY = 1; tick(); RREADY = 0;

    // ---- 5. backpressure ----
    drive_aw(32'h04); drive_w(32'h5, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    exp_regs[1*DW +: DW] = 32'h5;
    chk("bp_bvalid", BVALID, 1);
    drive_aw(32'h18); drive_w(32'h77, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    chk("bp_awready", AWREADY, 0);
    chk("bp_wready",  WREADY, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_bvalid_hold", BVALID, 1);
      chk("bp_bresp_hold",  BRESP, 2'b00);
    end
    chk("bp_regs_held", regs_o, exp_regs);
    BREADY = 1;
    tick();
    exp_regs[6*DW +: DW] = 32'h77;
    chk("bp_bvalid_2nd", BVALID, 1);
    chk("bp_regs_2nd",   regs_o, exp_regs);
    tick();
    BREADY = 0;
    chk("bp_bvalid_clr", BVALID, 0);
    ARADDR = 32'h18; ARVALID = 1;
    tick();
    ARADDR = 32'h08;
    tick(); tick();
    chk("bp_rvalid_hold", RVALID, 1);
    chk("bp_rdata_hold",  RDATA, 32'h77);
    chk("bp_arready",     ARREADY, 0);
    ARVALID = 0;
    RREADY = 1; tick(); RREADY = 0;
    chk("bp_rvalid_clr", RVALID, 0);

    // ---- 6. collision, then reset with BVALID pending ----
    drive_aw(32'h04); drive_w(32'h9, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'h04; ARVALID = 1;
    tick();
    ARVALID = 0;
    exp_regs[1*DW +: DW] = 32'h9;
    chk("col_rdata",  RDATA, 32'h5);
    chk("col_bvalid", BVALID, 1);
    chk("col_regs",   regs_o, exp_regs);
    BREADY = 1; RREADY = 1; tick(); BREADY = 0; RREADY = 0;

    drive_aw(32'h20); drive_w(32'h33, 4'hF);
    tick();
    AWVALID = 0; WVALID = 0;
    tick();
    chk("mr_bvalid", BVALID, 1);
    ARESETn = 0;
    tick();
    exp_regs = '0;
    chk("mr_bvalid_clr", BVALID, 0);
    chk("mr_regs",       regs_o, exp_regs);
    ARESETn = 1; BREADY = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_bbeat", BVALID, 0);
    end
    chk("mr_awready", AWREADY, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
